// File: rtl/riscv_fetch_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// riscv_fetch_queue
//
// Instruction-fetch stage for the RISC-V pipeline. A PC generator reads a
// programmable, word-addressed instruction memory and pushes each fetched
// {pc, instruction} pair into a small FIFO prefetch queue. The ID stage
// consumes the queue head, so short ID stalls do not stop fetch until the
// queue is full. A taken branch or jump flushes the queue and retargets fetch.
//
// Handshake: the head entry is offered whenever instr_valid=1. It is consumed
// (popped) on a rising clock edge where instr_valid=1 and stall=0. A redirect or
// program-mode cycle flushes the queue, and a pop on that edge is discarded.
//
// Ports
//   clock          in   rising-edge system clock
//   reset          in   asynchronous, active-high reset
//   prog_en        in   program mode: memory write enable, fetch held at PC 0
//   prog_addr      in   program-mode write address
//   prog_data      in   program-mode write data
//   redirect_valid in   taken branch / jump from EXE/MEM
//   redirect_pc    in   branch / jump target
//   stall          in   ID not ready; queue head is held
//   instr_valid    out  queue head is valid
//   instr_out      out  queue-head instruction (NOP_WORD when empty)
//   instr_pc       out  PC of the queue head (0 when empty)
//   fetch_pc       out  next PC to be fetched
//   queue_count    out  occupied queue entries
//   stall_cycles   out  (FETCH_PERF_CNT_EN only) cycles with a held valid head
//   bubble_cycles  out  (FETCH_PERF_CNT_EN only) cycles with no valid head
//
// Build option
//   FETCH_PERF_CNT_EN  when defined, adds two saturating 16-bit performance
//                      counters and their output ports.
//
// Parameters
//   PC_SIZE      PC / memory address width; memory depth is 2**PC_SIZE words
//   INSTR_WIDTH  instruction word width
//   FIFO_DEPTH   prefetch queue entries; power of two, at least 2
//   NOP_WORD     value presented on instr_out while the queue is empty
// -----------------------------------------------------------------------------
module riscv_fetch_queue #(
    parameter int                     PC_SIZE     = 10,
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     FIFO_DEPTH  = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 32'h00000013
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         prog_en,
    input  logic [PC_SIZE-1:0]           prog_addr,
    input  logic [INSTR_WIDTH-1:0]       prog_data,
    input  logic                         redirect_valid,
    input  logic [PC_SIZE-1:0]           redirect_pc,
    input  logic                         stall,
    output logic                         instr_valid,
    output logic [INSTR_WIDTH-1:0]       instr_out,
    output logic [PC_SIZE-1:0]           instr_pc,
    output logic [PC_SIZE-1:0]           fetch_pc,
    output logic [$clog2(FIFO_DEPTH):0]  queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]                  stall_cycles,
    output logic [15:0]                  bubble_cycles
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int MEM_DEPTH = 2 ** PC_SIZE;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // -------------------------------------------------------------------------
    // Instruction memory: synchronous write in program mode, asynchronous read
    // at the fetch PC. Not cleared by reset so a program survives a reset.
    // Fetch is held whenever prog_en=1, so a write never races a fetch read.
    // -------------------------------------------------------------------------
    logic [INSTR_WIDTH-1:0] imem_q [MEM_DEPTH];
    logic [INSTR_WIDTH-1:0] fetch_word;

    always_ff @(posedge clock) begin
        if (prog_en) begin
            imem_q[prog_addr] <= prog_data;
        end
    end

    // -------------------------------------------------------------------------
    // Queue state
    // -------------------------------------------------------------------------
    logic [INSTR_WIDTH-1:0] q_instr_q [FIFO_DEPTH];
    logic [PC_SIZE-1:0]     q_pc_q    [FIFO_DEPTH];

    logic [PW-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]      count_q,    count_d;
    logic [PC_SIZE-1:0] fetch_pc_q, fetch_pc_d;

    logic head_valid;
    logic pop;
    logic push;
    logic flush;

    assign fetch_word = imem_q[fetch_pc_q];
    assign head_valid = (count_q != '0);
    assign pop        = head_valid && !stall;
    assign flush      = prog_en || redirect_valid;
    // A full queue only accepts a new entry when the head leaves on the same
    // edge. Pointers are PW bits wide and wrap on their own.
    assign push       = !flush && ((count_q < DEPTH_C) || pop);

    // -------------------------------------------------------------------------
    // Next-state logic. Program mode beats redirect; both flush the queue and
    // discard any same-cycle pop.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;

        if (prog_en) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = '0;
        end else if (redirect_valid) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                // Wraps from all-ones back to 0 by truncation.
                fetch_pc_d = fetch_pc_q + PC_SIZE'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Queue storage carries no reset: every read is qualified by count_q,
    // which reset clears asynchronously.
    always_ff @(posedge clock) begin
        if (push) begin
            q_instr_q[wr_ptr_q] <= fetch_word;
            q_pc_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: head is combinational from storage, forced to NOP / PC 0 when
    // the queue is empty.
    // -------------------------------------------------------------------------
    assign instr_valid = head_valid;
    assign instr_out   = head_valid ? q_instr_q[rd_ptr_q] : NOP_WORD;
    assign instr_pc    = head_valid ? q_pc_q[rd_ptr_q]    : '0;
    assign fetch_pc    = fetch_pc_q;
    assign queue_count = count_q;

`ifdef FETCH_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters. Both saturate at all-ones and are held at zero
    // while the program loader owns the stage.
    // -------------------------------------------------------------------------
    logic [15:0] stall_cnt_q,  stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (prog_en) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (head_valid && stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (!head_valid && (bubble_cnt_q != 16'hFFFF)) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign bubble_cycles = bubble_cnt_q;
`endif

endmodule

// File: doc/riscv_fetch_queue.md
Name: riscv_fetch_queue

Overview:
Parametrised instruction-fetch stage for the RISC-V pipeline. It replaces the single-register IF stage with a PC generator, a programmable instruction memory and a FIFO prefetch queue. The queue decouples fetch from ID stalls and flushes on branch redirect. It sits between the program loader / branch resolution logic and the ID stage.

Parameters:
PC_SIZE, 10, PC and instruction-memory address width (word-addressed); memory depth is 2**PC_SIZE
INSTR_WIDTH, 32, instruction word width
FIFO_DEPTH, 4, prefetch queue entries; must be a power of two and at least 2
NOP_WORD, 32'h00000013, value driven on instr_out when the queue is empty

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
prog_en  input  1  program mode: memory write enable and fetch hold
prog_addr  input  PC_SIZE  program-mode write address
prog_data  input  INSTR_WIDTH  program-mode write data
redirect_valid  input  1  taken branch or jump from EXE/MEM
redirect_pc  input  PC_SIZE  branch target
stall  input  1  ID not ready; queue head is held
instr_valid  output  1  queue head is valid
instr_out  output  INSTR_WIDTH  queue-head instruction
instr_pc  output  PC_SIZE  PC of queue head
fetch_pc  output  PC_SIZE  next PC to be fetched
queue_count  output  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (asynchronous, active-high):
  - fetch_pc=0, queue_count=0, instr_valid=0, instr_out=NOP_WORD, instr_pc=0.
  - Instruction memory is not cleared.
- Instruction memory:
  - Write is synchronous: imem[prog_addr]<=prog_data on a clock edge when prog_en=1.
  - Read is asynchronous at fetch_pc.
- Pop: occurs when instr_valid=1 and stall=0.
- Push: occurs when prog_en=0, redirect_valid=0, and (queue_count<FIFO_DEPTH or pop).
  - Push writes {fetch_pc, imem[fetch_pc]} to the tail.
  - fetch_pc<=fetch_pc+1, wrapping modulo 2**PC_SIZE (from all-ones to 0).
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, push is permitted only with a same-cycle pop.
  - When empty, a pop cannot occur, so count goes 0 to 1.
- Output timing:
  - Head is combinational from FIFO storage.
  - An instruction fetched at edge t is visible at instr_out after edge t.
  - Fetch-to-output latency is 1 cycle.
- When empty: instr_valid=0, instr_out=NOP_WORD, instr_pc=0.
- Redirect (redirect_valid=1 at edge t):
  - Queue is flushed (count<=0), fetch_pc<=redirect_pc, no push.
  - Redirect overrides stall, and any pop is discarded.
  - The target instruction is pushed at edge t+1 and appears at instr_out after t+1.
- prog_en=1:
  - Queue is flushed and fetch_pc<=0 on every edge.
  - prog_en has priority over redirect.
  - Fetch resumes from address 0 on the first edge with prog_en=0.
- Stall held with a full queue: no push, fetch_pc is frozen, and head/outputs are stable.
- Read/write hazard: a prog_en write never coincides with fetch, because fetch is held, so no read-during-write hazard exists.
- Pointers: read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- Reset mid-operation: the queue is discarded immediately (asynchronously) and all outputs return to reset values.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs stall_cycles[15:0] and bubble_cycles[15:0].
  - stall_cycles increments each cycle with instr_valid=1 and stall=1.
  - bubble_cycles increments each cycle with instr_valid=0 and prog_en=0.
  - Both saturate at 16'hFFFF and clear on reset or while prog_en=1.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
1. Program and stream: prog_en=1 writes imem[0..5]=0xA0..0xA5, then prog_en=0 with stall=0 -> instr_out shows 0xA0, 0xA1, ... on consecutive cycles; instr_pc=0,1,2...; first valid one cycle after prog_en falls.
2. Fill under stall: stall=1 for 8 cycles after prog_en falls -> queue_count 1,2,3,4 then holds 4; fetch_pc=4; head stays 0xA0/pc 0. Release stall -> 0xA1..0xA5 delivered with no bubbles.
3. Redirect: redirect_valid=1 with redirect_pc=0x3F0 while queue_count=3 -> next cycle queue_count=0, instr_valid=0; following cycle instr_pc=0x3F0, instr_out=imem[0x3F0].
4. Wrap-around: redirect_pc=0x3FE -> instr_pc sequence 0x3FE, 0x3FF, 0x000, 0x001.
5. Priority: prog_en=1 and redirect_valid=1 in the same cycle -> fetch_pc=0 and queue empty. Redirect with stall=1 -> flush still occurs.
6. Async reset: assert reset mid-stream between clock edges -> instr_valid=0, queue_count=0, instr_out=NOP_WORD immediately. Memory contents are retained: after reset release, 0xA0 is refetched.
